sipo_deser: RTL
===============

# sipo_deser

Serial-in/parallel-out deserializer that consumes the registered single-bit stream produced by the upstream `d_ff` stage and assembles it into WIDTH-bit words. Completed words are presented on a valid/ready output handshake through a one-entry holding register; words that cannot be delivered are dropped and flagged. It sits directly downstream of the bit-retiming flop and feeds word-level logic.

## Interface
- `WIDTH`, default 8: word width in bits; legal range 2..32.
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `d_in`  in  1  serial data bit from the upstream flop.
- `d_in_valid`  in  1  `d_in` is sampled this cycle.
- `d_in_sof`  in  1  start-of-frame; qualified by `d_in_valid`; the current bit becomes bit 0 of a new word.
- `data_out`  out  WIDTH  assembled word, MSB = first bit received.
- `data_out_valid`  out  1  holding register is full.
- `data_out_ready`  in  1  downstream accepts `data_out` when `data_out_valid` is also high.
- `overrun`  out  1  one-cycle pulse: a completed word was dropped.
- `parity_err`  out  1  parity status for the word in the holding register.

## Operation
- Reset values: `data_out` = 0, `data_out_valid` = 0, `overrun` = 0, `parity_err` = 0, shift register = 0, bit counter = 0, FSM = SHIFT.
- FSM states:
  - SHIFT: on each `d_in_valid`, `shreg <= {shreg[WIDTH-2:0], d_in}` and the counter increments. When the WIDTH-1 bit is accepted, the word completes. With parity disabled the FSM stays in SHIFT and the counter wraps to 0. With parity enabled the FSM goes to PARITY.
  - PARITY (macro only): the next `d_in_valid` bit is the parity bit. The word completes on that bit, then the FSM returns to SHIFT with the counter at 0.
- Cycles without `d_in_valid` hold all shift and counter state.
- `d_in_sof` with `d_in_valid`:
  - The partial word is discarded without an overrun.
  - The counter is forced so that `d_in` is stored as bit 0, and the counter becomes 1.
  - The FSM goes to SHIFT, including when it was in PARITY.
  - `d_in_sof` without `d_in_valid` is ignored.
- Word completion loads the holding register:
  - Load when the register is empty, or when it is being drained in the same cycle (`data_out_valid && data_out_ready`). In that case valid stays high with the new word and there is no bubble.
  - Otherwise the new word is dropped, the old word is kept, and `overrun` pulses for one cycle.
- `data_out_valid` falls after a handshake only if no word completes in that cycle.
- `data_out` holds its value while valid is low. It is not cleared on drain.

## Timing
- Latency: the last bit (data or parity) is accepted at edge N, and `data_out`/`data_out_valid` are valid after edge N. They are visible in the cycle following the bit's `d_in_valid` cycle.
- `overrun` is asserted in the cycle after the dropped completion, for exactly one cycle.
- Maximum throughput: one word per WIDTH cycles, or WIDTH+1 cycles with parity, with `data_out_ready` held high.
- An `rst` assertion mid-word or mid-handshake immediately clears all state to the reset values. The partial word and any held word are lost.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Configuration
- `SIPO_PARITY_EN` defined:
  - The PARITY state is compiled in.
  - Each word is followed by one even-parity bit.
  - `parity_err` is loaded together with `data_out` and equals the XOR of the WIDTH data bits and the parity bit.
  - The word is delivered regardless of `parity_err`.
- `SIPO_PARITY_EN` undefined: there is no PARITY state, words are WIDTH bits, and the `parity_err` port remains present, tied to 0.

## Test plan
- Basic word (WIDTH=8, ready=1): send 1,0,1,0,0,1,0,1 on consecutive `d_in_valid` cycles -> `data_out` = 8'hA5 with `data_out_valid` high for 1 cycle, starting the cycle after the 8th bit; `overrun` stays 0.
- Gapped input: send 8'h3C with `d_in_valid` low for 2 cycles between every bit -> `data_out` = 8'h3C with no early valid.
- Backpressure/overrun: hold ready=0 and send 8'h11 then 8'h22 -> `data_out` stays 8'h11, `overrun` pulses once after the 16th bit; raising ready drains 8'h11, then valid drops.
- Same-cycle drain and load: ready=0 with 8'h11 held, then raise ready in the exact cycle the 8th bit of 8'h22 is accepted -> next cycle `data_out` = 8'h22, valid continuously high, no overrun.
- Resync and reset: send 3 bits, then `d_in_sof` plus 8'hF0 bits -> only 8'hF0 is output. Assert `rst` after 4 bits of the next word -> all outputs are 0 next cycle, and the following 8 bits form a clean word.
- Parity (`SIPO_PARITY_EN`): 8'hA5 with parity bit 0 -> `parity_err` = 0. 8'hA5 with parity bit 1 -> `data_out` = 8'hA5 and `parity_err` = 1, both appearing the cycle after the 9th bit.

Source files
------------

// File: rtl/sipo_deser.sv
// sipo_deser: serial-in/parallel-out deserializer.
//
// Collects the single-bit stream from the upstream retiming flop into
// WIDTH-bit words. The first bit received becomes the word MSB. Each
// completed word goes into a one-entry holding register behind a
// valid/ready handshake. A completed word that cannot enter the holding
// register is dropped, and overrun pulses for one cycle.
//
// Optional feature macro: SIPO_PARITY_EN
//   defined   : each word is followed by one even-parity bit. parity_err
//               is loaded with data_out and is high when the XOR of the
//               data bits and the parity bit is 1.
//   undefined : words are WIDTH bits and parity_err is tied to 0.
//
// Ports:
//   clk            in   system clock, rising edge
//   rst            in   asynchronous active-high reset
//   d_in           in   serial data bit
//   d_in_valid     in   d_in is sampled this cycle
//   d_in_sof       in   start of frame; d_in becomes bit 0 of a new word
//   data_out       out  assembled word (MSB = first bit received)
//   data_out_valid out  holding register full
//   data_out_ready in   downstream accepts data_out
//   overrun        out  one-cycle pulse: a completed word was dropped
//   parity_err     out  parity status of the held word
module sipo_deser #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             d_in,
  input  logic             d_in_valid,
  input  logic             d_in_sof,
  output logic [WIDTH-1:0] data_out,
  output logic             data_out_valid,
  input  logic             data_out_ready,
  output logic             overrun,
  output logic             parity_err
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             ovr_q, ovr_d;
  logic [WIDTH-1:0] shift_s;
  logic [WIDTH-1:0] word_s;
  logic             done_s;

`ifdef SIPO_PARITY_EN
  localparam logic [0:0] ST_SHIFT  = 1'b0;
  localparam logic [0:0] ST_PARITY = 1'b1;

  logic [0:0] state_q, state_d;
  logic       perr_q, perr_d;
  logic       perr_s;

  // High when the data bits and the received even-parity bit disagree.
  function automatic logic even_par_err(input logic [WIDTH-1:0] w, input logic p);
    even_par_err = (^w) ^ p;
  endfunction
`endif

  assign shift_s = {shreg_q[WIDTH-2:0], d_in};

  // Bit assembly: shifting, bit counting and word completion.
  always_comb begin
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    done_s  = 1'b0;
    word_s  = shift_s;
`ifdef SIPO_PARITY_EN
    state_d = state_q;
    perr_s  = 1'b0;
`endif
    if (d_in_valid) begin
      if (d_in_sof) begin
        // Resync: drop the partial word; this bit starts a fresh word.
        shreg_d = {{(WIDTH-1){1'b0}}, d_in};
        cnt_d   = CNT_ONE;
`ifdef SIPO_PARITY_EN
        state_d = ST_SHIFT;
`endif
      end else begin
`ifdef SIPO_PARITY_EN
        case (state_q)
          ST_PARITY: begin
            // Parity bit is not shifted in; the data word is already in shreg_q.
            done_s  = 1'b1;
            word_s  = shreg_q;
            perr_s  = even_par_err(shreg_q, d_in);
            cnt_d   = CNT_ZERO;
            state_d = ST_SHIFT;
          end
          ST_SHIFT: begin
            shreg_d = shift_s;
            if (cnt_q == CNT_LAST) begin
              cnt_d   = CNT_ZERO;
              state_d = ST_PARITY;
            end else begin
              cnt_d = cnt_q + CNT_ONE;
            end
          end
          default: begin
            cnt_d   = CNT_ZERO;
            state_d = ST_SHIFT;
          end
        endcase
`else
        shreg_d = shift_s;
        if (cnt_q == CNT_LAST) begin
          done_s = 1'b1;
          cnt_d  = CNT_ZERO;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
`endif
      end
    end else begin
      shreg_d = shreg_q;
    end
  end

  // Holding register: load on completion if empty or draining, else drop.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    ovr_d   = 1'b0;
`ifdef SIPO_PARITY_EN
    perr_d  = perr_q;
`endif
    if (done_s) begin
      if (!valid_q || data_out_ready) begin
        data_d  = word_s;
        valid_d = 1'b1;
`ifdef SIPO_PARITY_EN
        perr_d  = perr_s;
`endif
      end else begin
        ovr_d = 1'b1;
      end
    end else if (valid_q && data_out_ready) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  // State registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg_q <= {WIDTH{1'b0}};
      cnt_q   <= CNT_ZERO;
      data_q  <= {WIDTH{1'b0}};
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
`ifdef SIPO_PARITY_EN
      state_q <= ST_SHIFT;
      perr_q  <= 1'b0;
`endif
    end else begin
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
`ifdef SIPO_PARITY_EN
      state_q <= state_d;
      perr_q  <= perr_d;
`endif
    end
  end

  assign data_out       = data_q;
  assign data_out_valid = valid_q;
  assign overrun        = ovr_q;
`ifdef SIPO_PARITY_EN
  assign parity_err     = perr_q;
`else
  assign parity_err     = 1'b0;
`endif

endmodule
